// File: rtl/spi_flash_arbiter.sv
// rtl/spi_flash_arbiter.sv - shares one SPI flash between the DSP and CPU SPI masters
module spi_flash_arbiter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned TIMEOUT_WIDTH = 16,
    parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = 16'd40000
) (
    input  logic       sysclk,
    input  logic       reset_INV,
    input  logic       enable,
    input  logic       dsp_cs_INV,
    input  logic       dsp_clk,
    input  logic       dsp_mosi,
    output logic       dsp_miso,
    input  logic       cpu_cs_INV,
    input  logic       cpu_clk,
    input  logic       cpu_mosi,
    output logic       cpu_miso,
    output logic       flash_cs_INV,
    output logic       flash_clk,
    output logic       flash_mosi,
    input  logic       flash_miso,
    output logic [1:0] grant,
    output logic       timeout_event
);

    typedef enum logic [2:0] {IDLE, OWN_DSP, OWN_CPU, LOCKOUT, GAP} state_t;

    localparam logic OWNER_DSP = 1'b0;
    localparam logic OWNER_CPU = 1'b1;
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_CYCLES - TIMEOUT_WIDTH'(1);
    localparam logic [TIMEOUT_WIDTH-1:0] GAP_LAST = TIMEOUT_WIDTH'(GAP_CYCLES - 1);

    logic [SYNC_STAGES-1:0]   sync_dsp;
    logic [SYNC_STAGES-1:0]   sync_cpu;
    logic                     req_dsp;
    logic                     req_cpu;
    state_t                   state;
    state_t                   state_next;
    logic [TIMEOUT_WIDTH-1:0] cnt;
    logic [TIMEOUT_WIDTH-1:0] cnt_next;
    logic [TIMEOUT_WIDTH-1:0] cnt_inc;
    logic                     last_owner;
    logic                     last_owner_next;
    logic                     timeout_next;
    logic                     own_dsp;
    logic                     own_cpu;

    // Synchronizers keep tracking while disabled so a held CS is granted right after re-enable
    always_ff @(posedge sysclk) begin
        if (!reset_INV) begin
            sync_dsp <= '0;
            sync_cpu <= '0;
        end else begin
            sync_dsp <= {sync_dsp[SYNC_STAGES-2:0], ~dsp_cs_INV};
            sync_cpu <= {sync_cpu[SYNC_STAGES-2:0], ~cpu_cs_INV};
        end
    end

    assign req_dsp = sync_dsp[SYNC_STAGES-1];
    assign req_cpu = sync_cpu[SYNC_STAGES-1];

    always_ff @(posedge sysclk) begin
        if (!reset_INV) begin
            state         <= IDLE;
            cnt           <= '0;
            last_owner    <= OWNER_CPU;
            timeout_event <= 1'b0;
        end else if (!enable) begin
            state         <= IDLE;
            cnt           <= '0;
            timeout_event <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            last_owner    <= last_owner_next;
            timeout_event <= timeout_next;
        end
    end

    assign cnt_inc = (cnt == '1) ? cnt : cnt + TIMEOUT_WIDTH'(1);

    always_comb begin
        state_next      = state;
        cnt_next        = cnt_inc;
        last_owner_next = last_owner;
        timeout_next    = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                // On a tie the master that did not own last time wins
                if (req_dsp && (!req_cpu || last_owner == OWNER_CPU)) begin
                    state_next      = OWN_DSP;
                    last_owner_next = OWNER_DSP;
                end else if (req_cpu) begin
                    state_next      = OWN_CPU;
                    last_owner_next = OWNER_CPU;
                end
            end
            OWN_DSP, OWN_CPU: begin
                if (!((state == OWN_DSP) ? req_dsp : req_cpu)) begin
                    state_next = GAP;
                    cnt_next   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_next   = LOCKOUT;
                    cnt_next     = '0;
                    timeout_next = 1'b1;
                end
            end
            LOCKOUT: begin
                if (!((last_owner == OWNER_CPU) ? req_cpu : req_dsp)) begin
                    state_next = GAP;
                    cnt_next   = '0;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Data path is purely combinational so SPI timing is set only by the masters
    assign own_dsp      = (state == OWN_DSP);
    assign own_cpu      = (state == OWN_CPU);
    assign grant        = {own_cpu, own_dsp};
    assign flash_cs_INV = own_dsp ? dsp_cs_INV : (own_cpu ? cpu_cs_INV : 1'b1);
    assign flash_clk    = (own_dsp & dsp_clk) | (own_cpu & cpu_clk);
    assign flash_mosi   = (own_dsp & dsp_mosi) | (own_cpu & cpu_mosi);
    assign dsp_miso     = own_dsp & flash_miso;
    assign cpu_miso     = own_cpu & flash_miso;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb/tb_spi_flash_arbiter.sv - directed self-checking bench for spi_flash_arbiter
module tb_spi_flash_arbiter;

    localparam int TIMEOUT = 40000;

    logic       sysclk = 1'b0;
    logic       reset_INV = 1'b0;
    logic       enable = 1'b1;
    logic       dsp_cs_INV = 1'b1;
    logic       dsp_clk = 1'b0;
    logic       dsp_mosi = 1'b0;
    logic       dsp_miso;
    logic       cpu_cs_INV = 1'b1;
    logic       cpu_clk = 1'b0;
    logic       cpu_mosi = 1'b0;
    logic       cpu_miso;
    logic       flash_cs_INV;
    logic       flash_clk;
    logic       flash_mosi;
    logic       flash_miso = 1'b0;
    logic [1:0] grant;
    logic       timeout_event;

    int total = 0;
    int bad = 0;

    spi_flash_arbiter dut (
        .sysclk(sysclk), .reset_INV(reset_INV), .enable(enable),
        .dsp_cs_INV(dsp_cs_INV), .dsp_clk(dsp_clk), .dsp_mosi(dsp_mosi), .dsp_miso(dsp_miso),
        .cpu_cs_INV(cpu_cs_INV), .cpu_clk(cpu_clk), .cpu_mosi(cpu_mosi), .cpu_miso(cpu_miso),
        .flash_cs_INV(flash_cs_INV), .flash_clk(flash_clk), .flash_mosi(flash_mosi),
        .flash_miso(flash_miso), .grant(grant), .timeout_event(timeout_event)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #2_000_000;
        $display("FAIL sim_time_limit: got=expired exp=finished");
        $fatal(1, "time limit");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #2;
        end
    endtask

    task automatic test_reset();
        reset_INV = 1'b0;
        tick(3);
        reset_INV = 1'b1;
        dsp_clk = 1'b1; dsp_mosi = 1'b1; cpu_clk = 1'b1; cpu_mosi = 1'b1; flash_miso = 1'b1;
        #1;
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant: got=%b exp=00", grant); end
        total++; if (flash_cs_INV !== 1'b1) begin bad++; $display("FAIL reset_cs: got=%b exp=1", flash_cs_INV); end
        total++; if (flash_clk !== 1'b0) begin bad++; $display("FAIL reset_clk: got=%b exp=0", flash_clk); end
        total++; if (flash_mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi: got=%b exp=0", flash_mosi); end
        total++; if ({dsp_miso, cpu_miso} !== 2'b00) begin bad++; $display("FAIL reset_miso: got=%b exp=00", {dsp_miso, cpu_miso}); end
        total++; if (timeout_event !== 1'b0) begin bad++; $display("FAIL reset_timeout: got=%b exp=0", timeout_event); end
        dsp_clk = 1'b0; dsp_mosi = 1'b0; cpu_clk = 1'b0; cpu_mosi = 1'b0; flash_miso = 1'b0;
        tick(2);
    endtask

    task automatic test_tie_after_reset();
        dsp_cs_INV = 1'b0; cpu_cs_INV = 1'b0;
        tick(2);
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL tie_early: got=%b exp=00", grant); end
        tick(1);
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL tie_dsp_wins: got=%b exp=01", grant); end
        flash_miso = 1'b1;
        #1;
        total++; if ({dsp_miso, cpu_miso} !== 2'b10) begin bad++; $display("FAIL tie_miso: got=%b exp=10", {dsp_miso, cpu_miso}); end
        flash_miso = 1'b0;
        dsp_cs_INV = 1'b1;
        tick(7);
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL tie_gap: got=%b exp=00", grant); end
        tick(1);
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL tie_cpu_next: got=%b exp=10", grant); end
        dsp_cs_INV = 1'b0;
        tick(3);
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL tie_cpu_holds: got=%b exp=10", grant); end
        cpu_cs_INV = 1'b1;
        tick(7);
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL tie_gap2: got=%b exp=00", grant); end
        tick(1);
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL tie_dsp_next: got=%b exp=01", grant); end
        dsp_cs_INV = 1'b1;
        tick(10);
    endtask

    task automatic test_dsp_alone();
        dsp_cs_INV = 1'b0;
        tick(2);
        total++; if (flash_cs_INV !== 1'b1) begin bad++; $display("FAIL alone_cs_early: got=%b exp=1", flash_cs_INV); end
        tick(1);
        total++; if (flash_cs_INV !== 1'b0) begin bad++; $display("FAIL alone_cs_latency: got=%b exp=0", flash_cs_INV); end
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL alone_grant: got=%b exp=01", grant); end
        dsp_clk = 1'b1; dsp_mosi = 1'b1; flash_miso = 1'b1; cpu_clk = 1'b1;
        #1;
        total++; if ({flash_clk, flash_mosi} !== 2'b11) begin bad++; $display("FAIL alone_clk_mosi_hi: got=%b exp=11", {flash_clk, flash_mosi}); end
        total++; if ({dsp_miso, cpu_miso} !== 2'b10) begin bad++; $display("FAIL alone_miso: got=%b exp=10", {dsp_miso, cpu_miso}); end
        dsp_clk = 1'b0; dsp_mosi = 1'b0; flash_miso = 1'b0; cpu_clk = 1'b0;
        #1;
        total++; if ({flash_clk, flash_mosi} !== 2'b00) begin bad++; $display("FAIL alone_clk_mosi_lo: got=%b exp=00", {flash_clk, flash_mosi}); end
        dsp_cs_INV = 1'b1;
        #1;
        total++; if (flash_cs_INV !== 1'b1) begin bad++; $display("FAIL alone_cs_release: got=%b exp=1", flash_cs_INV); end
        tick(10);
    endtask

    task automatic test_contention();
        cpu_cs_INV = 1'b0;
        tick(3);
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL cont_cpu_grant: got=%b exp=10", grant); end
        dsp_cs_INV = 1'b0;
        tick(5);
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL cont_cpu_holds: got=%b exp=10", grant); end
        flash_miso = 1'b1; dsp_clk = 1'b1; cpu_clk = 1'b0;
        #1;
        total++; if ({dsp_miso, cpu_miso} !== 2'b01) begin bad++; $display("FAIL cont_miso: got=%b exp=01", {dsp_miso, cpu_miso}); end
        total++; if ({flash_cs_INV, flash_clk} !== 2'b00) begin bad++; $display("FAIL cont_cs_clk: got=%b exp=00", {flash_cs_INV, flash_clk}); end
        flash_miso = 1'b0; dsp_clk = 1'b0;
        cpu_cs_INV = 1'b1;
        #1;
        total++; if (flash_cs_INV !== 1'b1) begin bad++; $display("FAIL cont_cs_follows: got=%b exp=1", flash_cs_INV); end
        tick(7);
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL cont_gap: got=%b exp=00", grant); end
        tick(1);
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL cont_dsp_next: got=%b exp=01", grant); end
        dsp_cs_INV = 1'b1;
        tick(10);
    endtask

    task automatic test_watchdog();
        int err;
        err = 0;
        cpu_cs_INV = 1'b0;
        tick(3);
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL wd_grant: got=%b exp=10", grant); end
        dsp_cs_INV = 1'b0;
        repeat (TIMEOUT - 1) begin
            tick(1);
            if (grant !== 2'b10 || timeout_event !== 1'b0) err++;
        end
        total++; if (err !== 0) begin bad++; $display("FAIL wd_hold: got=%0d exp=0 bad cycles", err); end
        tick(1);
        total++; if ({grant, timeout_event} !== 3'b001) begin bad++; $display("FAIL wd_fire: got=%b exp=001", {grant, timeout_event}); end
        total++; if (flash_cs_INV !== 1'b1) begin bad++; $display("FAIL wd_cs: got=%b exp=1", flash_cs_INV); end
        tick(1);
        total++; if (timeout_event !== 1'b0) begin bad++; $display("FAIL wd_pulse_width: got=%b exp=0", timeout_event); end
        tick(20);
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL wd_lockout: got=%b exp=00", grant); end
        cpu_cs_INV = 1'b1;
        tick(7);
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL wd_gap: got=%b exp=00", grant); end
        tick(1);
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL wd_dsp_next: got=%b exp=01", grant); end
    endtask

    task automatic test_enable_drop();
        dsp_clk = 1'b1;
        enable = 1'b0;
        tick(1);
        total++; if ({grant, flash_cs_INV, flash_clk} !== 4'b0010) begin bad++; $display("FAIL en_drop: got=%b exp=0010", {grant, flash_cs_INV, flash_clk}); end
        tick(5);
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL en_ignored: got=%b exp=00", grant); end
        enable = 1'b1;
        tick(1);
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL en_regrant: got=%b exp=01", grant); end
        dsp_clk = 1'b0;
    endtask

    task automatic test_sync_reset();
        dsp_clk = 1'b1; dsp_mosi = 1'b1;
        reset_INV = 1'b0;
        tick(1);
        total++; if ({grant, flash_cs_INV, flash_clk, flash_mosi} !== 5'b00100) begin bad++; $display("FAIL rst_mid: got=%b exp=00100", {grant, flash_cs_INV, flash_clk, flash_mosi}); end
        reset_INV = 1'b1;
        dsp_cs_INV = 1'b1; dsp_clk = 1'b0; dsp_mosi = 1'b0;
        tick(5);
        dsp_cs_INV = 1'b0; cpu_cs_INV = 1'b0;
        tick(3);
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL rst_tie: got=%b exp=01", grant); end
        dsp_cs_INV = 1'b1; cpu_cs_INV = 1'b1;
        tick(10);
    endtask

    initial begin
        test_reset();
        test_tie_after_reset();
        test_dsp_alone();
        test_contention();
        test_watchdog();
        test_enable_drop();
        test_sync_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
